// File: rtl/code_check_ctrl.sv
// ---------------------------------------------------------------------------
// code_check_ctrl
//
// Sequencing controller for the 4-press button code receiver. It arms the
// receiver, waits for a complete 4-digit entry, then compares the entry
// against the CODE secret one digit at a time. The compare stops at the first
// wrong digit, so time-to-fail reveals how many leading digits matched; this
// leak is the point of the timing-attack demo. The pass/fail indication is
// then held for RESULT_CYCLES and the receiver is re-armed.
//
// Parameters
//   CODE           secret; digit k is CODE[2k+1:2k], digit 0 is the first press
//   CHECK_CYCLES   cycles spent comparing each digit (>= 1)
//   RESULT_CYCLES  cycles unlock/fail is held (>= 1)
//   TIMEOUT_CYCLES idle cycles after a partial entry before abandoning it
//                  (0 disables the timeout)
//
// Ports
//   clk            system clock, single domain
//   reset          synchronous, active-high
//   rx_done        receiver has captured 4 presses
//   rx_code        receiver's captured digits, 2 bits each
//   rx_activity    one-cycle pulse per accepted press
//   rx_clear       synchronous clear to the receiver, one cycle per re-arm
//   unlock         entry matched; held RESULT_CYCLES
//   fail           entry mismatched; held RESULT_CYCLES
//   busy           high while comparing or holding a result
//   digits_matched leading digits matched on the last compare, 0..4
//   attempt_count  completed compares since reset, saturating at 255
// ---------------------------------------------------------------------------
module code_check_ctrl #(
    parameter logic [7:0]  CODE           = 8'b10_01_00_10,
    parameter int unsigned CHECK_CYCLES   = 4,
    parameter int unsigned RESULT_CYCLES  = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done,
    input  logic [7:0] rx_code,
    input  logic       rx_activity,
    output logic       rx_clear,
    output logic       unlock,
    output logic       fail,
    output logic       busy,
    output logic [2:0] digits_matched,
    output logic [7:0] attempt_count
);

    localparam int unsigned CNT_W  = (CHECK_CYCLES   > 1) ? $clog2(CHECK_CYCLES)   : 1;
    localparam int unsigned RES_W  = (RESULT_CYCLES  > 1) ? $clog2(RESULT_CYCLES)  : 1;
    localparam int unsigned IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CHECK_CYCLES - 1);
    localparam logic [RES_W-1:0]  RES_LAST  = RES_W'(RESULT_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST =
        IDLE_W'((TIMEOUT_CYCLES == 0) ? 32'd0 : TIMEOUT_CYCLES - 1);
    localparam logic              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        S_CLEAR   = 2'd0,
        S_WAIT    = 2'd1,
        S_COMPARE = 2'd2,
        S_RESULT  = 2'd3
    } state_e;

    state_e             state_q;
    logic               rx_clear_q;
    logic               unlock_q;
    logic               fail_q;
    logic               busy_q;
    logic [2:0]         digits_matched_q;
    logic [7:0]         attempt_q;
    logic [7:0]         code_q;
    logic [1:0]         digit_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [RES_W-1:0]   res_cnt_q;
    logic [IDLE_W-1:0]  idle_q;
    logic               seen_q;

    logic [1:0]         entry_digit;
    logic [1:0]         secret_digit;
    logic               digit_match;

    // Current digit under test; value 2'b11 can never be a valid press.
    always_comb begin
        entry_digit  = code_q[{digit_q, 1'b0} +: 2];
        secret_digit = CODE[{digit_q, 1'b0} +: 2];
        digit_match  = (entry_digit != 2'b11) && (entry_digit == secret_digit);
    end

    // Controller state, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_CLEAR;
            rx_clear_q       <= 1'b1;
            unlock_q         <= 1'b0;
            fail_q           <= 1'b0;
            busy_q           <= 1'b0;
            digits_matched_q <= 3'd0;
            attempt_q        <= 8'd0;
            code_q           <= 8'd0;
            digit_q          <= 2'd0;
            cnt_q            <= '0;
            res_cnt_q        <= '0;
            idle_q           <= '0;
            seen_q           <= 1'b0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    // Receiver clears on this edge; we are armed from here on.
                    rx_clear_q <= 1'b0;
                    seen_q     <= 1'b0;
                    idle_q     <= '0;
                    state_q    <= S_WAIT;
                end

                S_WAIT: begin
                    // rx_done beats both a press and a timeout in the same cycle.
                    if (rx_done) begin
                        code_q  <= rx_code;
                        digit_q <= 2'd0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_COMPARE;
                    end else if (rx_activity) begin
                        seen_q <= 1'b1;
                        idle_q <= '0;
                    end else if (seen_q) begin
                        if (TIMEOUT_EN && (idle_q == IDLE_LAST)) begin
                            rx_clear_q <= 1'b1;
                            state_q    <= S_CLEAR;
                        end else begin
                            idle_q <= idle_q + IDLE_W'(1);
                        end
                    end
                end

                S_COMPARE: begin
                    if (cnt_q == CNT_LAST) begin
                        if (!digit_match) begin
                            fail_q           <= 1'b1;
                            digits_matched_q <= {1'b0, digit_q};
                            res_cnt_q        <= '0;
                            state_q          <= S_RESULT;
                            if (attempt_q != 8'hFF) begin
                                attempt_q <= attempt_q + 8'd1;
                            end
                        end else if (digit_q == 2'd3) begin
                            unlock_q         <= 1'b1;
                            digits_matched_q <= 3'd4;
                            res_cnt_q        <= '0;
                            state_q          <= S_RESULT;
                            if (attempt_q != 8'hFF) begin
                                attempt_q <= attempt_q + 8'd1;
                            end
                        end else begin
                            digit_q <= digit_q + 2'd1;
                            cnt_q   <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_RESULT: begin
                    if (res_cnt_q == RES_LAST) begin
                        unlock_q   <= 1'b0;
                        fail_q     <= 1'b0;
                        busy_q     <= 1'b0;
                        rx_clear_q <= 1'b1;
                        state_q    <= S_CLEAR;
                    end else begin
                        res_cnt_q <= res_cnt_q + RES_W'(1);
                    end
                end

                default: begin
                    rx_clear_q <= 1'b1;
                    state_q    <= S_CLEAR;
                end
            endcase
        end
    end

    assign rx_clear       = rx_clear_q;
    assign unlock         = unlock_q;
    assign fail           = fail_q;
    assign busy           = busy_q;
    assign digits_matched = digits_matched_q;
    assign attempt_count  = attempt_q;

endmodule

// File: tb/tb_code_check_ctrl.sv
// ---------------------------------------------------------------------------
// tb_code_check_ctrl
//
// Directed bench for code_check_ctrl with CHECK_CYCLES=4, RESULT_CYCLES=8,
// TIMEOUT_CYCLES=20. Inputs are driven and outputs sampled 1 time unit after
// each rising edge.
// ---------------------------------------------------------------------------
module tb_code_check_ctrl;

    localparam logic [7:0]  CODE           = 8'b10_01_00_10;
    localparam int unsigned CHECK_CYCLES   = 4;
    localparam int unsigned RESULT_CYCLES  = 8;
    localparam int unsigned TIMEOUT_CYCLES = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done;
    logic [7:0] rx_code;
    logic       rx_activity;
    logic       rx_clear;
    logic       unlock;
    logic       fail;
    logic       busy;
    logic [2:0] digits_matched;
    logic [7:0] attempt_count;

    int total = 0;
    int bad   = 0;
    int exp_ac = 0;

    code_check_ctrl #(
        .CODE           (CODE),
        .CHECK_CYCLES   (CHECK_CYCLES),
        .RESULT_CYCLES  (RESULT_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rx_done        (rx_done),
        .rx_code        (rx_code),
        .rx_activity    (rx_activity),
        .rx_clear       (rx_clear),
        .unlock         (unlock),
        .fail           (fail),
        .busy           (busy),
        .digits_matched (digits_matched),
        .attempt_count  (attempt_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one complete entry and measure the resulting attempt.
    task automatic do_entry(input logic [7:0] code, output int lat, output int hold,
                            output logic saw_unlock, output logic saw_fail,
                            output logic [2:0] dm, output logic saw_both,
                            output logic busy_e0, output logic clr_exit,
                            output logic clr_after);
        rx_code = code;
        rx_done = 1'b1;
        tick(1);
        rx_done = 1'b0;
        rx_code = ~code;
        busy_e0 = busy;
        lat = 0;
        while (!(unlock || fail) && lat < 200) begin
            tick(1);
            lat++;
        end
        saw_unlock = unlock;
        saw_fail   = fail;
        dm         = digits_matched;
        saw_both   = 1'b0;
        hold       = 0;
        while ((unlock || fail) && hold < 200) begin
            if (unlock && fail) saw_both = 1'b1;
            hold++;
            tick(1);
        end
        clr_exit = rx_clear && !busy;
        tick(1);
        clr_after = rx_clear;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        rx_done     = 1'b0;
        rx_activity = 1'b0;
        rx_code     = 8'd0;
        tick(3);
        total++; if (rx_clear !== 1'b1) begin bad++; $display("FAIL reset rx_clear: got %b want 1", rx_clear); end
        total++; if (unlock !== 1'b0) begin bad++; $display("FAIL reset unlock: got %b want 0", unlock); end
        total++; if (fail !== 1'b0) begin bad++; $display("FAIL reset fail: got %b want 0", fail); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
        total++; if (digits_matched !== 3'd0) begin bad++; $display("FAIL reset digits_matched: got %0d want 0", digits_matched); end
        total++; if (attempt_count !== 8'd0) begin bad++; $display("FAIL reset attempt_count: got %0d want 0", attempt_count); end
        reset = 1'b0;
        tick(1);
        total++; if (rx_clear !== 1'b0) begin bad++; $display("FAIL reset release rx_clear: got %b want 0", rx_clear); end
        exp_ac = 0;
    endtask

    task automatic test_pass();
        int lat, hold;
        logic su, sf, sb, be0, ce, ca;
        logic [2:0] dm;
        do_entry(CODE, lat, hold, su, sf, dm, sb, be0, ce, ca);
        exp_ac++;
        total++; if (lat != 16) begin bad++; $display("FAIL pass latency: got %0d want 16", lat); end
        total++; if (su !== 1'b1 || sf !== 1'b0) begin bad++; $display("FAIL pass flags: got unlock=%b fail=%b want 1/0", su, sf); end
        total++; if (hold != 8) begin bad++; $display("FAIL pass hold: got %0d want 8", hold); end
        total++; if (dm !== 3'd4) begin bad++; $display("FAIL pass digits_matched: got %0d want 4", dm); end
        total++; if (sb !== 1'b0) begin bad++; $display("FAIL pass both flags high: got %b want 0", sb); end
        total++; if (be0 !== 1'b1) begin bad++; $display("FAIL pass busy at entry: got %b want 1", be0); end
        total++; if (ce !== 1'b1 || ca !== 1'b0) begin bad++; $display("FAIL pass rx_clear pulse: got exit=%b after=%b want 1/0", ce, ca); end
        total++; if (attempt_count !== 8'(exp_ac)) begin bad++; $display("FAIL pass attempt_count: got %0d want %0d", attempt_count, exp_ac); end
        tick(3);
        total++; if (digits_matched !== 3'd4) begin bad++; $display("FAIL pass digits_matched hold: got %0d want 4", digits_matched); end
    endtask

    task automatic test_mismatch();
        logic [7:0] codes [5];
        int         lats  [5];
        int         dms   [5];
        int lat, hold;
        logic su, sf, sb, be0, ce, ca;
        logic [2:0] dm;
        codes = '{8'b10_01_00_00, 8'b10_01_01_10, 8'b10_00_00_10, 8'b00_01_00_10, 8'b10_01_00_11};
        lats  = '{4, 8, 12, 16, 4};
        dms   = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            do_entry(codes[i], lat, hold, su, sf, dm, sb, be0, ce, ca);
            exp_ac++;
            total++; if (lat != lats[i]) begin bad++; $display("FAIL mismatch[%0d] latency: got %0d want %0d", i, lat, lats[i]); end
            total++; if (su !== 1'b0 || sf !== 1'b1) begin bad++; $display("FAIL mismatch[%0d] flags: got unlock=%b fail=%b want 0/1", i, su, sf); end
            total++; if (hold != 8) begin bad++; $display("FAIL mismatch[%0d] hold: got %0d want 8", i, hold); end
            total++; if (int'(dm) != dms[i]) begin bad++; $display("FAIL mismatch[%0d] digits_matched: got %0d want %0d", i, dm, dms[i]); end
            total++; if (ce !== 1'b1 || ca !== 1'b0) begin bad++; $display("FAIL mismatch[%0d] rx_clear pulse: got exit=%b after=%b want 1/0", i, ce, ca); end
            total++; if (attempt_count !== 8'(exp_ac)) begin bad++; $display("FAIL mismatch[%0d] attempt_count: got %0d want %0d", i, attempt_count, exp_ac); end
        end
    endtask

    task automatic test_timeout();
        int   n;
        logic seen_clr, seen_res;
        seen_clr = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (rx_clear) seen_clr = 1'b1;
        end
        total++; if (seen_clr !== 1'b0) begin bad++; $display("FAIL timeout idle without press: got rx_clear=%b want 0", seen_clr); end
        // First press, then a second one that must restart the idle count.
        rx_activity = 1'b1; tick(1); rx_activity = 1'b0;
        tick(10);
        rx_activity = 1'b1; tick(1); rx_activity = 1'b0;
        n = 0;
        seen_res = 1'b0;
        while (!rx_clear && n < 100) begin
            tick(1);
            n++;
            if (unlock || fail || busy) seen_res = 1'b1;
        end
        total++; if (n != 20) begin bad++; $display("FAIL timeout delay: got %0d want 20", n); end
        total++; if (seen_res !== 1'b0) begin bad++; $display("FAIL timeout result seen: got %b want 0", seen_res); end
        total++; if (attempt_count !== 8'(exp_ac)) begin bad++; $display("FAIL timeout attempt_count: got %0d want %0d", attempt_count, exp_ac); end
        tick(1);
        total++; if (rx_clear !== 1'b0) begin bad++; $display("FAIL timeout rx_clear width: got %b want 0", rx_clear); end
    endtask

    task automatic test_done_on_timeout();
        int lat, hold;
        logic su, sf, sb, be0, ce, ca;
        logic [2:0] dm;
        rx_activity = 1'b1; tick(1); rx_activity = 1'b0;
        tick(19);
        total++; if (rx_clear !== 1'b0) begin bad++; $display("FAIL done_on_timeout early clear: got %b want 0", rx_clear); end
        do_entry(CODE, lat, hold, su, sf, dm, sb, be0, ce, ca);
        exp_ac++;
        total++; if (be0 !== 1'b1) begin bad++; $display("FAIL done_on_timeout busy: got %b want 1", be0); end
        total++; if (lat != 16 || su !== 1'b1) begin bad++; $display("FAIL done_on_timeout result: got lat=%0d unlock=%b want 16/1", lat, su); end
        total++; if (attempt_count !== 8'(exp_ac)) begin bad++; $display("FAIL done_on_timeout attempt_count: got %0d want %0d", attempt_count, exp_ac); end
    endtask

    task automatic test_reset_mid();
        logic seen_res;
        // Reset while a fail is being held.
        rx_code = 8'b10_01_00_00; rx_done = 1'b1; tick(1); rx_done = 1'b0;
        tick(4);
        total++; if (fail !== 1'b1) begin bad++; $display("FAIL reset_mid fail before reset: got %b want 1", fail); end
        reset = 1'b1; tick(1);
        total++; if (fail !== 1'b0 || busy !== 1'b0 || rx_clear !== 1'b1) begin bad++; $display("FAIL reset_mid result: got fail=%b busy=%b rx_clear=%b want 0/0/1", fail, busy, rx_clear); end
        total++; if (attempt_count !== 8'd0 || digits_matched !== 3'd0) begin bad++; $display("FAIL reset_mid result counters: got ac=%0d dm=%0d want 0/0", attempt_count, digits_matched); end
        reset = 1'b0; tick(1);
        // Reset at edge 6 of a passing compare.
        rx_code = CODE; rx_done = 1'b1; tick(1); rx_done = 1'b0;
        tick(5);
        reset = 1'b1; tick(1);
        total++; if (unlock !== 1'b0 || fail !== 1'b0 || busy !== 1'b0 || rx_clear !== 1'b1) begin bad++; $display("FAIL reset_mid compare: got u=%b f=%b busy=%b clr=%b want 0/0/0/1", unlock, fail, busy, rx_clear); end
        reset = 1'b0; tick(1);
        total++; if (rx_clear !== 1'b0) begin bad++; $display("FAIL reset_mid release rx_clear: got %b want 0", rx_clear); end
        seen_res = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (unlock || fail) seen_res = 1'b1;
        end
        total++; if (seen_res !== 1'b0) begin bad++; $display("FAIL reset_mid stray result: got %b want 0", seen_res); end
        total++; if (attempt_count !== 8'd0) begin bad++; $display("FAIL reset_mid attempt_count: got %0d want 0", attempt_count); end
        exp_ac = 0;
    endtask

    task automatic test_saturation();
        int lat, hold;
        logic su, sf, sb, be0, ce, ca;
        logic [2:0] dm;
        for (int i = 1; i <= 256; i++) begin
            do_entry(8'b10_01_00_00, lat, hold, su, sf, dm, sb, be0, ce, ca);
            if (i == 254) begin
                total++; if (attempt_count !== 8'd254) begin bad++; $display("FAIL saturation at 254: got %0d want 254", attempt_count); end
            end
            if (i == 255) begin
                total++; if (attempt_count !== 8'd255) begin bad++; $display("FAIL saturation at 255: got %0d want 255", attempt_count); end
            end
        end
        total++; if (attempt_count !== 8'd255) begin bad++; $display("FAIL saturation at 256: got %0d want 255", attempt_count); end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_mismatch();
        test_timeout();
        test_done_on_timeout();
        test_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/code_check_ctrl.md
# code_check_ctrl

Sequencing controller for the 4-press button code receiver in the timing-attack demo. It arms the receiver, waits for a complete 4-digit entry and compares the entry against a parameterised secret digit by digit. The compare exits on the first mismatching digit, so time-to-fail leaks the match length by design. The controller then holds a pass/fail indication and re-arms the receiver for the next attempt.

## Interface
- CODE, 8'b10_01_00_10, secret; digit k is CODE[2k+1:2k]; digit 0 is the first press
- CHECK_CYCLES, 4, cycles spent per digit compare (≥1)
- RESULT_CYCLES, 50_000_000, cycles unlock/fail is held (≥1)
- TIMEOUT_CYCLES, 500_000_000, idle cycles after a partial entry before abandoning it; 0 disables
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high
- rx_done  in  1  receiver has captured 4 presses
- rx_code  in  8  receiver's captured digits, 2 bits each
- rx_activity  in  1  one-cycle pulse per accepted press (receiver's ORed oneshots)
- rx_clear  out  1  synchronous clear to receiver (drives its reset)
- unlock  out  1  entry matched; held RESULT_CYCLES
- fail  out  1  entry mismatched; held RESULT_CYCLES
- busy  out  1  high in COMPARE and RESULT
- digits_matched  out  3  leading digits matched on last compare, 0–4
- attempt_count  out  8  completed compares since reset, saturating at 255

## Operation
- States: CLEAR, WAIT, COMPARE, RESULT. All outputs are registered.
- CLEAR (one cycle):
  - rx_clear=1; entry-seen flag cleared; idle counter cleared.
  - Next state is WAIT.
- WAIT:
  - rx_clear=0.
  - rx_done=1: latch rx_code into code_q, digit=0, cnt=0, go to COMPARE.
  - rx_done has priority over rx_activity and over timeout in the same cycle.
  - rx_activity=1: set the entry-seen flag and zero the idle counter.
  - Otherwise, while entry-seen is set, the idle counter increments.
  - Idle counter reaching TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES≠0): go to CLEAR. No count change, no result.
- COMPARE:
  - cnt increments each cycle.
  - When cnt==CHECK_CYCLES-1, evaluate code_q[2·digit+1:2·digit] against the CODE digit.
  - Mismatch: fail=1, digits_matched=digit, go to RESULT.
  - Match with digit==3: unlock=1, digits_matched=4, go to RESULT.
  - Match otherwise: digit+1, cnt=0.
  - Digit value 2'b11 always mismatches.
  - rx_code changes after the latch are ignored.
- RESULT:
  - attempt_count increments once, saturating, on COMPARE→RESULT.
  - Hold unlock/fail for RESULT_CYCLES cycles, clearing them on exit.
  - Next state is CLEAR.
  - rx_activity is ignored in COMPARE and RESULT.
- digits_matched holds its value until the next compare completes.

## Timing
- Reset values:
  - State CLEAR; rx_clear=1.
  - unlock=0, fail=0, busy=0, digits_matched=0, attempt_count=0.
  - All counters are 0.
  - The first cycle after reset deasserts is CLEAR, so the receiver is cleared again.
- rx_clear is high exactly one cycle per re-arm. The receiver clears on that edge; the controller is in WAIT from that edge on.
- Latency is counted from the edge that samples rx_done=1 in WAIT:
  - Pass: unlock rises at edge 4·CHECK_CYCLES (16 at the default).
  - Fail at digit k: fail rises at edge (k+1)·CHECK_CYCLES (4, 8, 12, 16).
- busy rises on the WAIT→COMPARE edge and falls on the RESULT→CLEAR edge.
- unlock or fail is high exactly RESULT_CYCLES cycles; the two are never both high.
- Reset mid-COMPARE or mid-RESULT:
  - Next edge gives the reset values.
  - The in-flight attempt is not counted.
  - Any held unlock/fail drops immediately.
- Timeout fires exactly TIMEOUT_CYCLES cycles after the last rx_activity pulse. With no press seen, WAIT waits forever.

## Test plan
Run with CHECK_CYCLES=4, RESULT_CYCLES=8 and TIMEOUT_CYCLES=20 where the scenario needs them.
- Correct entry: rx_code=8'b10_01_00_10, rx_done=1.
  - unlock high 16 edges later, for 8 cycles; digits_matched=4; attempt_count=1.
  - Then one rx_clear pulse.
- Wrong digit 0 (rx_code=8'b10_01_00_00): fail at edge 4, digits_matched=0.
- Wrong digit 3 (rx_code=8'b00_01_00_10): fail at edge 16, digits_matched=3.
- Digit value 11 (rx_code=8'b10_01_00_11): fail at edge 4, digits_matched=0. Receiver-illegal value, exercised to check the mismatch rule.
- Timeout: one rx_activity pulse, then silence.
  - rx_clear pulses exactly 20 cycles later.
  - No unlock/fail; attempt_count unchanged.
  - rx_done arriving on the timeout cycle wins and enters COMPARE.
- Reset at edge 6 of a compare: all outputs return to reset values; no result pulse; attempt_count=0.
- 256 failed attempts: attempt_count saturates at 255.
